// File: rtl/hyperbus_pkg.sv
// Shared types for the HyperBus controller blocks.
package hyperbus_pkg;

  // Receive upsizer control states: waiting for a command, or packing words.
  typedef enum logic {
    Idle    = 1'b0,
    Collect = 1'b1
  } hyper_rx_upsizer_state_t;

endpackage

// File: rtl/hyperbus_rx_upsizer.sv
// Packs the 16-bit PHY read stream into DataWidth-wide output beats.
// Each beat carries per-byte strobes, a sticky error, and a burst-last flag.
// The first beat may start at any lane. Lanes that were never written read as zero.
module hyperbus_rx_upsizer
  import hyperbus_pkg::*;
#(
  parameter int DataWidth = 64,
  parameter int LenWidth  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [$clog2(DataWidth/16)-1:0] cmd_offset_i,
  input  logic [LenWidth-1:0]        cmd_len_i,
  input  logic                       rx_valid_i,
  output logic                       rx_ready_o,
  input  logic [15:0]                rx_data_i,
  input  logic                       rx_error_i,
  input  logic                       rx_last_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DataWidth-1:0]       out_data_o,
  output logic [DataWidth/8-1:0]     out_strb_o,
  output logic                       out_error_o,
  output logic                       out_last_o
);

  localparam int NumLanes     = DataWidth / 16;
  localparam int LaneIdxWidth = $clog2(NumLanes);
  localparam int StrbWidth    = DataWidth / 8;

  hyper_rx_upsizer_state_t r_state, w_state_next;

  logic [LaneIdxWidth-1:0] r_lane;
  logic [LenWidth-1:0]     r_cnt;
  logic [LenWidth-1:0]     r_len;
  logic [DataWidth-1:0]    r_acc_data;
  logic [StrbWidth-1:0]    r_acc_strb;
  logic                    r_acc_err;
  logic                    r_out_valid;
  logic [DataWidth-1:0]    r_out_data;
  logic [StrbWidth-1:0]    r_out_strb;
  logic                    r_out_err;
  logic                    r_out_last;

  logic                    w_rx_ready;
  logic                    w_rx_hs;
  logic [LenWidth-1:0]     w_cnt_next;
  logic                    w_len_hit;
  logic                    w_final;
  logic                    w_beat_done;
  logic                    w_beat_err;
  logic [DataWidth-1:0]    w_merge_data;
  logic [StrbWidth-1:0]    w_merge_strb;

  // Accepting a word needs the output register to be free, or to drain in the same cycle.
  assign w_rx_ready  = (r_state == Collect) && (!r_out_valid || out_ready_i);
  assign w_rx_hs     = rx_valid_i && w_rx_ready;
  assign w_cnt_next  = r_cnt + LenWidth'(1);
  assign w_len_hit   = (w_cnt_next == r_len);
  assign w_final     = w_rx_hs && (rx_last_i || w_len_hit);
  assign w_beat_done = w_rx_hs && ((r_lane == LaneIdxWidth'(NumLanes - 1)) || rx_last_i || w_len_hit);
  // The PHY's last flag and the length count must agree. Either one arriving alone is a truncated or overrun burst.
  assign w_beat_err  = r_acc_err || rx_error_i || (rx_last_i != w_len_hit);

  // Overlay the incoming word on the accumulator so a completing beat includes it.
  always_comb begin
    w_merge_data = r_acc_data;
    w_merge_strb = r_acc_strb;
    w_merge_data[16*r_lane +: 16] = rx_data_i;
    w_merge_strb[2*r_lane +: 2]   = 2'b11;
  end

  // Next state and handshake readiness.
  always_comb begin
    w_state_next = r_state;
    cmd_ready_o  = 1'b0;
    rx_ready_o   = 1'b0;
    case (r_state)
      Idle: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) w_state_next = Collect;
      end
      Collect: begin
        rx_ready_o = w_rx_ready;
        if (w_final) w_state_next = Idle;
      end
      default: w_state_next = Idle;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= Idle;
    else         r_state <= w_state_next;
  end

  // Burst bookkeeping and the partial-beat accumulator.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lane     <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_acc_data <= '0;
      r_acc_strb <= '0;
      r_acc_err  <= 1'b0;
    end else if (r_state == Idle && cmd_valid_i) begin
      r_lane     <= cmd_offset_i;
      r_cnt      <= '0;
      r_len      <= cmd_len_i;
      r_acc_data <= '0;
      r_acc_strb <= '0;
      r_acc_err  <= 1'b0;
    end else if (w_rx_hs) begin
      r_cnt <= w_cnt_next;
      if (w_beat_done) begin
        r_lane     <= '0;
        r_acc_data <= '0;
        r_acc_strb <= '0;
        r_acc_err  <= 1'b0;
      end else begin
        r_lane     <= r_lane + LaneIdxWidth'(1);
        r_acc_data <= w_merge_data;
        r_acc_strb <= w_merge_strb;
        r_acc_err  <= r_acc_err || rx_error_i;
      end
    end
  end

  // Output register. A completing beat reloads it even while it drains, so there is no bubble.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_strb  <= '0;
      r_out_err   <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_beat_done) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_merge_data;
      r_out_strb  <= w_merge_strb;
      r_out_err   <= w_beat_err;
      r_out_last  <= w_final;
    end else if (out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign out_strb_o  = r_out_strb;
  assign out_error_o = r_out_err;
  assign out_last_o  = r_out_last;

endmodule
